// File: rtl/reg_file_if.sv
// Register file access bundle: write port (data, index, enable, stall),
// two read indices, two read data words and the written-since-reset bitmap.
interface reg_file_if #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
);
  logic [WIDTH-1:0]  in;
  logic [ADDR_W-1:0] inaddress;
  logic              write;
  logic              busywait;
  logic [ADDR_W-1:0] out1address;
  logic [ADDR_W-1:0] out2address;
  logic [WIDTH-1:0]  regout1;
  logic [WIDTH-1:0]  regout2;
  logic [DEPTH-1:0]  written;

  modport master (
    output in, inaddress, write, busywait,
    output out1address, out2address,
    input  regout1, regout2, written
  );

  modport slave (
    input  in, inaddress, write, busywait,
    input  out1address, out2address,
    output regout1, regout2, written
  );
endinterface

// File: rtl/reg_file.sv
// Architectural register file: two combinational read ports, one clocked
// write port stalled by busywait, async active-high rst clears all state.
// Ports: clk, rst, bus (reg_file_if.slave: in/inaddress/write/busywait,
// out1address/out2address -> regout1/regout2, written sticky bitmap).
// Optional write-through forwarding: define REG_FILE_BYPASS_EN.
module reg_file #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input logic        clk,
  input logic        rst,
  reg_file_if.slave  bus
);

  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] written_q;
  logic             wr_ok;
  logic             in_rng;
  logic             rd1_rng;
  logic             rd2_rng;

  assign in_rng  = {1'b0, bus.inaddress}   < DEPTH_C;
  assign rd1_rng = {1'b0, bus.out1address} < DEPTH_C;
  assign rd2_rng = {1'b0, bus.out2address} < DEPTH_C;

  // Single qualified enable shared by the array and the forwarding path.
  assign wr_ok = bus.write & ~bus.busywait & ~rst & in_rng;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs      <= '{default: '0};
      written_q <= '0;
    end else if (wr_ok) begin
      regs[bus.inaddress]      <= bus.in;
      written_q[bus.inaddress] <= 1'b1;
    end
  end

  always_comb begin
    bus.regout1 = '0;
    bus.regout2 = '0;
    if (rd1_rng) bus.regout1 = regs[bus.out1address];
    if (rd2_rng) bus.regout2 = regs[bus.out2address];
`ifdef REG_FILE_BYPASS_EN
    // wr_ok already implies an in-range target, so equality is enough.
    if (wr_ok && bus.out1address == bus.inaddress)
      bus.regout1 = bus.in;
    if (wr_ok && bus.out2address == bus.inaddress)
      bus.regout2 = bus.in;
`endif
  end

  assign bus.written = written_q;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table, hand sequences
// for reset/stall/out-of-range, and random traffic against an array model.
module tb_reg_file;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_file_if #(.WIDTH(8), .DEPTH(8), .ADDR_W(3)) bus ();
  reg_file_if #(.WIDTH(8), .DEPTH(6), .ADDR_W(3)) bus6 ();

  reg_file #(.WIDTH(8), .DEPTH(8), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  reg_file #(.WIDTH(8), .DEPTH(6), .ADDR_W(3)) dut6 (
    .clk(clk), .rst(rst), .bus(bus6)
  );

  typedef struct {
    logic       wr;
    logic       bw;
    logic [2:0] wa;
    logic [7:0] wd;
    logic [2:0] r1;
    logic [2:0] r2;
    logic [7:0] pre1;
    logic [7:0] pre2;
    logic [7:0] post1;
    logic [7:0] post2;
    logic [7:0] postw;
  } vec_t;

  vec_t tv [8];
  int nvec = 0;
  int nmis = 0;

  logic [7:0] m [8];
  logic [7:0] mw;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic bw, input logic [2:0] wa,
                       input logic [7:0] wd, input logic [2:0] r1,
                       input logic [2:0] r2);
    bus.write       = wr;
    bus.busywait    = bw;
    bus.inaddress   = wa;
    bus.in          = wd;
    bus.out1address = r1;
    bus.out2address = r2;
  endtask

  function automatic logic [7:0] fwd(input logic [7:0] old, input logic wr,
                                     input logic bw, input logic [2:0] wa,
                                     input logic [7:0] wd,
                                     input logic [2:0] ra);
    logic [7:0] v;
    v = old;
`ifdef REG_FILE_BYPASS_EN
    if (wr && !bw && ra == wa) v = wd;
`endif
    return v;
  endfunction

  initial begin
    logic       wr, bw;
    logic [2:0] wa, r1, r2;
    logic [7:0] wd;

    tv[0] = '{1, 0, 3, 8'hA5, 3, 3, 8'h00, 8'h00, 8'hA5, 8'hA5, 8'h08};
    tv[1] = '{1, 1, 5, 8'h3C, 5, 3, 8'h00, 8'hA5, 8'h00, 8'hA5, 8'h08};
    tv[2] = '{1, 1, 5, 8'h3C, 5, 3, 8'h00, 8'hA5, 8'h00, 8'hA5, 8'h08};
    tv[3] = '{1, 1, 5, 8'h3C, 5, 3, 8'h00, 8'hA5, 8'h00, 8'hA5, 8'h08};
    tv[4] = '{1, 0, 5, 8'h3C, 5, 5, 8'h00, 8'h00, 8'h3C, 8'h3C, 8'h28};
    tv[5] = '{1, 0, 2, 8'h11, 2, 0, 8'h00, 8'h00, 8'h11, 8'h00, 8'h2C};
    tv[6] = '{1, 0, 2, 8'h7F, 2, 2, 8'h11, 8'h11, 8'h7F, 8'h7F, 8'h2C};
    tv[7] = '{0, 0, 7, 8'hEE, 7, 2, 8'h00, 8'h7F, 8'h00, 8'h7F, 8'h2C};

    for (int i = 0; i < 8; i++) m[i] = 8'h00;
    mw = 8'h00;

    drive(1'b1, 1'b0, 3'd1, 8'h55, 3'd0, 3'd0);
    bus6.write = 1'b0; bus6.busywait = 1'b0; bus6.inaddress = '0;
    bus6.in = '0; bus6.out1address = '0; bus6.out2address = '0;

    // Reset held from time 0 with a write presented: all reads zero.
    #2;
    for (int a = 0; a < 8; a++) begin
      bus.out1address = 3'(a);
      bus.out2address = 3'(7 - a);
      #1;
      chk($sformatf("rst_rd1[%0d]", a), bus.regout1, 8'h00);
      chk($sformatf("rst_rd2[%0d]", 7 - a), bus.regout2, 8'h00);
    end
    chk("rst_written", bus.written, 8'h00);
    drive(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed table: pre-edge (old value) and post-edge checks.
    for (int i = 0; i < 8; i++) begin
      drive(tv[i].wr, tv[i].bw, tv[i].wa, tv[i].wd, tv[i].r1, tv[i].r2);
      #1;
      chk($sformatf("tv%0d_pre1", i), bus.regout1,
          fwd(tv[i].pre1, tv[i].wr, tv[i].bw, tv[i].wa, tv[i].wd, tv[i].r1));
      chk($sformatf("tv%0d_pre2", i), bus.regout2,
          fwd(tv[i].pre2, tv[i].wr, tv[i].bw, tv[i].wa, tv[i].wd, tv[i].r2));
      @(posedge clk);
      #1;
      if (tv[i].wr && !tv[i].bw) begin
        m[tv[i].wa] = tv[i].wd;
        mw[tv[i].wa] = 1'b1;
      end
      chk($sformatf("tv%0d_post1", i), bus.regout1, tv[i].post1);
      chk($sformatf("tv%0d_post2", i), bus.regout2, tv[i].post2);
      chk($sformatf("tv%0d_written", i), bus.written, tv[i].postw);
    end

    // Random traffic against the array model.
    for (int n = 0; n < 300; n++) begin
      wr = ($urandom_range(0, 3) != 0);
      bw = ($urandom_range(0, 3) == 0);
      wa = 3'($urandom_range(0, 7));
      wd = 8'($urandom);
      r1 = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
      r2 = 3'($urandom_range(0, 7));
      drive(wr, bw, wa, wd, r1, r2);
      #1;
      chk("rnd_pre1", bus.regout1, fwd(m[r1], wr, bw, wa, wd, r1));
      chk("rnd_pre2", bus.regout2, fwd(m[r2], wr, bw, wa, wd, r2));
      @(posedge clk);
      #1;
      if (wr && !bw) begin
        m[wa] = wd;
        mw[wa] = 1'b1;
      end
      chk("rnd_written", bus.written, mw);
      chk("rnd_post1", bus.regout1, fwd(m[r1], wr, bw, wa, wd, r1));
    end

    // Fill every register, then reset between edges.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 3'(i), 8'(8'h10 + i), 3'(i), 3'd0);
      @(posedge clk);
      #1;
      chk($sformatf("fill_rd[%0d]", i), bus.regout1, 8'(8'h10 + i));
    end
    chk("fill_written", bus.written, 8'hFF);
    drive(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
    #2;
    rst = 1'b1;
    #1;
    for (int a = 0; a < 8; a++) begin
      bus.out1address = 3'(a);
      bus.out2address = 3'(a);
      #1;
      chk($sformatf("midrst_rd1[%0d]", a), bus.regout1, 8'h00);
      chk($sformatf("midrst_rd2[%0d]", a), bus.regout2, 8'h00);
    end
    chk("midrst_written", bus.written, 8'h00);
    drive(1'b1, 1'b0, 3'd4, 8'h99, 3'd4, 3'd4);
    #1;
    chk("rstheld_bypass", bus.regout1, 8'h00);
    @(posedge clk);
    #1;
    chk("rstheld_rd", bus.regout1, 8'h00);
    chk("rstheld_written", bus.written, 8'h00);
    drive(1'b0, 1'b0, 3'd4, 8'h99, 3'd4, 3'd4);
    #2;
    rst = 1'b0;
    #1;
    chk("rstrel_rd", bus.regout1, 8'h00);
    chk("rstrel_written", bus.written, 8'h00);

    // Reduced-depth instance: out-of-range write and reads.
    for (int i = 0; i < 6; i++) begin
      bus6.write = 1'b1;
      bus6.inaddress = 3'(i);
      bus6.in = 8'(8'h20 + i);
      @(posedge clk);
      #1;
    end
    chk("d6_fill_written", 32'(bus6.written), 32'h3F);
    bus6.inaddress = 3'd7;
    bus6.in = 8'hFF;
    bus6.out1address = 3'd7;
    #1;
    chk("d6_oor_pre", bus6.regout1, 8'h00);
    @(posedge clk);
    #1;
    bus6.write = 1'b0;
    chk("d6_oor_written", 32'(bus6.written), 32'h3F);
    chk("d6_oor_rd7", bus6.regout1, 8'h00);
    bus6.out1address = 3'd6;
    #1;
    chk("d6_oor_rd6", bus6.regout1, 8'h00);
    for (int i = 0; i < 6; i++) begin
      bus6.out2address = 3'(i);
      #1;
      chk($sformatf("d6_keep[%0d]", i), bus6.regout2, 8'(8'h20 + i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
